// File: rtl/hand_card_inserter_pkg.sv
// hand_card_inserter_pkg: board map geometry, card codes and the slot-extract helper
package hand_card_inserter_pkg;
  localparam int SLOT_W     = 6;
  localparam int MAP_SLOTS  = 144;
  localparam int HAND_SLOTS = 36;
  localparam int IDX_W      = 6;
  localparam int MAP_W      = MAP_SLOTS * SLOT_W;
  localparam int MAP_AW     = $clog2(MAP_W);
  localparam logic [SLOT_W-1:0] NO_CARD  = 6'd54;
  localparam logic [SLOT_W-1:0] MAX_CARD = 6'd53;
  // Slot 0 occupies the most significant bits of the map
  function automatic logic [SLOT_W-1:0] slot_of(input logic [MAP_W-1:0] map, input logic [IDX_W-1:0] idx);
    logic [MAP_AW-1:0] top;
    top = MAP_AW'(MAP_W - 1) - MAP_AW'(idx) * MAP_AW'(SLOT_W);
    return map[top -: SLOT_W];
  endfunction
endpackage

// File: rtl/hand_card_inserter_if.sv
// hand_card_inserter_if: draw request, map view and map write port between draw logic and the inserter
interface hand_card_inserter_if;
  import hand_card_inserter_pkg::*;
  logic [MAP_W-1:0]  map;
  logic              draw_req;
  logic [SLOT_W-1:0] draw_card;
  logic              busy;
  logic              map_wr_en;
  logic [IDX_W-1:0]  map_wr_idx;
  logic [SLOT_W-1:0] map_wr_data;
  logic              done;
  logic [IDX_W-1:0]  card_place;
  logic              hand_full;
  logic              invalid_card;
  modport master (
    output map, draw_req, draw_card,
    input  busy, map_wr_en, map_wr_idx, map_wr_data, done, card_place, hand_full, invalid_card
  );
  modport slave (
    input  map, draw_req, draw_card,
    output busy, map_wr_en, map_wr_idx, map_wr_data, done, card_place, hand_full, invalid_card
  );
endinterface

// File: rtl/hand_card_inserter_map_slot_mux.sv
// map_slot_mux: selects one 6-bit slot code out of the packed board map
module map_slot_mux
  import hand_card_inserter_pkg::*;
(
  input  logic [MAP_W-1:0]  map_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [SLOT_W-1:0] slot_o
);
  assign slot_o = slot_of(map_i, idx_i);
endmodule

// File: rtl/hand_card_inserter.sv
// hand_card_inserter: writes a drawn card into the lowest empty hand slot of the board map
module hand_card_inserter
  import hand_card_inserter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic interboard_rst,
  hand_card_inserter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_e;
  typedef struct packed {
    state_e            state;
    logic [SLOT_W-1:0] card;
    logic [IDX_W-1:0]  idx;
    logic              busy;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [SLOT_W-1:0] wr_data;
    logic              done;
    logic [IDX_W-1:0]  place;
    logic              full;
    logic              inv;
  } regs_t;
  regs_t r_q;
  logic [SLOT_W-1:0] slot;
  map_slot_mux u_mux (.map_i(bus.map), .idx_i(r_q.idx), .slot_o(slot));
  // Scan FSM; every port is driven straight from a register, pulses clear themselves each cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (interboard_rst) begin
      r_q <= '0;
    end else begin
      r_q.wr_en <= 1'b0;
      r_q.done  <= 1'b0;
      r_q.full  <= 1'b0;
      r_q.inv   <= 1'b0;
      case (r_q.state)
        IDLE: if (bus.draw_req) begin
          r_q.card <= bus.draw_card;
          r_q.idx  <= '0;
          if (bus.draw_card > MAX_CARD) begin
            r_q.inv <= 1'b1;
          end else begin
            r_q.state <= SCAN;
            r_q.busy  <= 1'b1;
          end
        end
        SCAN: if (slot == NO_CARD) begin
          r_q.state   <= WRITE;
          r_q.wr_en   <= 1'b1;
          r_q.wr_idx  <= r_q.idx;
          r_q.wr_data <= r_q.card;
        end else if (r_q.idx == IDX_W'(HAND_SLOTS - 1)) begin
          r_q.state <= IDLE;
          r_q.busy  <= 1'b0;
          r_q.full  <= 1'b1;
        end else begin
          r_q.idx <= r_q.idx + 1'b1;
        end
        WRITE: begin
          r_q.state <= DONE;
          r_q.done  <= 1'b1;
          r_q.place <= r_q.idx;
        end
        default: begin
          r_q.state <= IDLE;
          r_q.busy  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.busy         = r_q.busy;
  assign bus.map_wr_en    = r_q.wr_en;
  assign bus.map_wr_idx   = r_q.wr_idx;
  assign bus.map_wr_data  = r_q.wr_data;
  assign bus.done         = r_q.done;
  assign bus.card_place   = r_q.place;
  assign bus.hand_full    = r_q.full;
  assign bus.invalid_card = r_q.inv;
endmodule

// File: tb/tb_hand_card_inserter.sv
// tb_hand_card_inserter: scoreboard bench for the hand card inserter
module tb_hand_card_inserter;
  import hand_card_inserter_pkg::*;
  typedef struct {int kind; int idx; int data; int cyc;} ev_t;
  localparam int EV_WR = 1, EV_DONE = 2, EV_FULL = 3, EV_INV = 4;
  logic clk = 1'b0, rst = 1'b0, ibr = 1'b0;
  int cyc = 0, checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;
  bit busy_seen = 1'b0;
  ev_t sb[$];
  logic [SLOT_W-1:0] slots [MAP_SLOTS];
  hand_card_inserter_if ifc();
  hand_card_inserter dut (.clk(clk), .rst(rst), .interboard_rst(ibr), .bus(ifc));
  // Free-running clock
  always #5 clk = ~clk;
  // Cycle counter read on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fill(input int n_full);
    for (int i = 0; i < MAP_SLOTS; i++) slots[i] = (i < n_full && i < HAND_SLOTS) ? SLOT_W'(i % 54) : NO_CARD;
  endtask

  task automatic load_map();
    logic [MAP_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAP_SLOTS; i++) m = {m[MAP_W-SLOT_W-1:0], slots[i]};
    ifc.map = m;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic req(input logic [SLOT_W-1:0] c, input bit expect_it, output int t);
    ev_t e;
    int k;
    t = cyc;
    k = -1;
    if (expect_it) begin
      if (c > MAX_CARD) begin
        e = '{EV_INV, 0, 0, t + 1}; sb.push_back(e);
      end else begin
        for (int i = 0; i < HAND_SLOTS; i++) if (k < 0 && slots[i] == NO_CARD) k = i;
        if (k < 0) begin
          e = '{EV_FULL, 0, 0, t + HAND_SLOTS + 1}; sb.push_back(e);
        end else begin
          e = '{EV_WR, k, int'(c), t + 2 + k}; sb.push_back(e);
          e = '{EV_DONE, k, 0, t + 3 + k}; sb.push_back(e);
        end
      end
    end
    ifc.draw_card = c;
    ifc.draw_req = 1'b1;
    @(negedge clk);
    ifc.draw_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || ifc.busy) && n < 80) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL drain: %0d events pending busy=%b, required 0 pending and idle", sb.size(), ifc.busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ifc.busy, ifc.map_wr_en, ifc.done, ifc.hand_full, ifc.invalid_card, ifc.card_place, ifc.map_wr_idx, ifc.map_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b wr=%b done=%b full=%b inv=%b place=%0d, required all 0",
               ifc.busy, ifc.map_wr_en, ifc.done, ifc.hand_full, ifc.invalid_card, ifc.card_place);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int t, w0;
    fill(0); load_map();
    w0 = wr_cnt;
    req(6'd17, 1'b1, t);
    drain();
    checks++;
    if (ifc.card_place !== 6'd0 || wr_cnt - w0 != 1) begin
      errors++;
      $display("FAIL empty_place: place=%0d writes=%0d, required 0 and 1", ifc.card_place, wr_cnt - w0);
    end
  endtask

  task automatic test_slot10();
    int t;
    fill(10); load_map();
    req(6'd40, 1'b1, t);
    drain();
    checks++;
    if (ifc.card_place !== 6'd10) begin
      errors++;
      $display("FAIL slot10_place: place=%0d, required 10", ifc.card_place);
    end
  endtask

  task automatic test_full();
    int t, w0;
    fill(HAND_SLOTS); load_map();
    w0 = wr_cnt;
    req(6'd5, 1'b1, t);
    wait_until(t + 36);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL full_busy_last_scan: busy=%b, required 1", ifc.busy);
    end
    wait_until(t + 37);
    checks++;
    if (ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy_after: busy=%b, required 0", ifc.busy);
    end
    drain();
    checks++;
    if (wr_cnt != w0 || ifc.card_place !== 6'd10) begin
      errors++;
      $display("FAIL full_no_write: writes=%0d place=%0d, required 0 and 10", wr_cnt - w0, ifc.card_place);
    end
  endtask

  task automatic test_last_slot();
    int t;
    fill(HAND_SLOTS); slots[HAND_SLOTS-1] = NO_CARD; load_map();
    req(MAX_CARD, 1'b1, t);
    drain();
    checks++;
    if (ifc.card_place !== 6'd35) begin
      errors++;
      $display("FAIL last_place: place=%0d, required 35", ifc.card_place);
    end
  endtask

  task automatic test_invalid();
    int t, t2, w0;
    fill(0); load_map();
    w0 = wr_cnt;
    busy_seen = 1'b0;
    req(6'd54, 1'b1, t);
    req(6'd63, 1'b1, t2);
    drain();
    repeat (2) @(negedge clk);
    checks++;
    if (busy_seen || wr_cnt != w0 || ifc.card_place !== 6'd35) begin
      errors++;
      $display("FAIL invalid_side_effects: busy_seen=%b writes=%0d place=%0d, required 0, 0, 35",
               busy_seen, wr_cnt - w0, ifc.card_place);
    end
  endtask

  task automatic test_ignored();
    int t, t2, w0, d0;
    fill(10); load_map();
    w0 = wr_cnt; d0 = done_cnt;
    req(6'd9, 1'b1, t);
    wait_until(t + 3);
    req(6'd20, 1'b0, t2);
    drain();
    repeat (5) @(negedge clk);
    checks++;
    if (wr_cnt - w0 != 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL ignored_req: writes=%0d dones=%0d, required 1 and 1", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_rst_mid();
    int t, w0, d0;
    fill(10); load_map();
    w0 = wr_cnt; d0 = done_cnt;
    req(6'd30, 1'b1, t);
    wait_until(t + 6);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if ({ifc.busy, ifc.map_wr_en, ifc.done, ifc.hand_full, ifc.invalid_card, ifc.card_place} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b wr=%b done=%b place=%0d, required all 0",
               ifc.busy, ifc.map_wr_en, ifc.done, ifc.card_place);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (14) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || done_cnt != d0) begin
      errors++;
      $display("FAIL rst_mid_silent: writes=%0d dones=%0d, required 0 and 0", wr_cnt - w0, done_cnt - d0);
    end
    slots[3] = NO_CARD; load_map();
    req(6'd12, 1'b1, t);
    drain();
    checks++;
    if (ifc.card_place !== 6'd3) begin
      errors++;
      $display("FAIL rst_mid_recover: place=%0d, required 3", ifc.card_place);
    end
  endtask

  task automatic test_soft_rst();
    int t, w0, d0;
    fill(10); load_map();
    w0 = wr_cnt; d0 = done_cnt;
    req(6'd31, 1'b1, t);
    wait_until(t + 6);
    ibr = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if ({ifc.busy, ifc.map_wr_en, ifc.done, ifc.hand_full, ifc.invalid_card, ifc.card_place} !== '0) begin
      errors++;
      $display("FAIL soft_rst_outputs: busy=%b wr=%b done=%b place=%0d, required all 0",
               ifc.busy, ifc.map_wr_en, ifc.done, ifc.card_place);
    end
    ibr = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || done_cnt != d0) begin
      errors++;
      $display("FAIL soft_rst_silent: writes=%0d dones=%0d, required 0 and 0", wr_cnt - w0, done_cnt - d0);
    end
    fill(0); load_map();
    req(6'd7, 1'b1, t);
    drain();
    checks++;
    if (ifc.card_place !== 6'd0) begin
      errors++;
      $display("FAIL soft_rst_recover: place=%0d, required 0", ifc.card_place);
    end
  endtask

  // Stimulus sequence with a scoreboard monitor and a watchdog running alongside
  initial begin
    ifc.draw_req = 1'b0;
    ifc.draw_card = '0;
    fill(0); load_map();
    fork
      forever begin
        ev_t e;
        int kind, idx, data, n;
        @(negedge clk);
        if (ifc.busy) busy_seen = 1'b1;
        n = $countones({ifc.map_wr_en, ifc.done, ifc.hand_full, ifc.invalid_card});
        if (n != 0) begin
          kind = ifc.map_wr_en ? EV_WR : ifc.done ? EV_DONE : ifc.hand_full ? EV_FULL : EV_INV;
          idx  = ifc.map_wr_en ? int'(ifc.map_wr_idx) : ifc.done ? int'(ifc.card_place) : 0;
          data = ifc.map_wr_en ? int'(ifc.map_wr_data) : 0;
          if (ifc.map_wr_en) wr_cnt++;
          if (ifc.done) done_cnt++;
          checks++;
          if (n > 1 || sb.size() == 0) begin
            errors++;
            $display("FAIL event: got %0d pulses kind=%0d idx=%0d data=%0d cycle=%0d, required none", n, kind, idx, data, cyc);
          end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.idx != idx || e.data != data || e.cyc != cyc) begin
              errors++;
              $display("FAIL event: got kind=%0d idx=%0d data=%0d cycle=%0d, required kind=%0d idx=%0d data=%0d cycle=%0d",
                       kind, idx, data, cyc, e.kind, e.idx, e.data, e.cyc);
            end
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_empty();
    test_slot10();
    test_full();
    test_last_slot();
    test_invalid();
    test_ignored();
    test_rst_mid();
    test_soft_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
